// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter:
// state encodings, select encodings and the idle-state select picker.
package mux_rr_arbiter_pkg;

   // Arbiter states; values are kept identical to the legacy header encodings.
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] BUSY_A = 2'd1;
   localparam logic [1:0] BUSY_B = 2'd2;

   // Mux select encodings (s=0 steers A, s=1 steers B).
   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   // Round-robin pick while idle. A lone requester wins outright, a tie goes
   // to whoever was not served last, and with no request the select holds.
   function automatic logic pick_sel(input logic req_a,
                                     input logic req_b,
                                     input logic last,
                                     input logic prev);
      logic pick;
      pick = prev;
      case ({req_a, req_b})
         2'b10:   pick = SEL_A;
         2'b01:   pick = SEL_B;
         2'b11:   pick = (last == SEL_A) ? SEL_B : SEL_A;
         default: pick = prev;
      endcase
      return pick;
   endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux.sv
// Team 4-bit 2:1 mux used as the data steering element of the arbiter.
// s=0 passes A, s=1 passes B. Purely combinational.
module mux (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       s,
   output logic [3:0] Y
);

   // Steer one of the two words to the output.
   always_comb begin
      Y = A;
      if (s) begin
         Y = B;
      end
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that shares the 2:1 mux between two requesters,
// captures the selected word and holds it until the consumer takes it
// through a valid/ready handshake. Also counts completed handshakes.
module mux_rr_arbiter
   import mux_rr_arbiter_pkg::*;
#(
   parameter int W     = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_a,
   input  logic [W-1:0]     data_a,
   input  logic             req_b,
   input  logic [W-1:0]     data_b,
   input  logic             out_ready,
   output logic             gnt_a,
   output logic             gnt_b,
   output logic             sel,
   output logic [W-1:0]     y,
   output logic             y_valid,
   output logic [CNT_W-1:0] xfer_count
);

   logic [1:0]   state;
   logic         last;      // requester served most recently
   logic         sel_q;     // select remembered across cycles
   logic         sel_idle;  // select proposed by the round-robin picker
   logic         capture;   // a word is taken at this edge
   logic         handshake; // the held word is accepted at this edge
   logic [W-1:0] mux_y;

   // Work out the select the picker would choose from the current requests.
   always_comb begin
      sel_idle = pick_sel(req_a, req_b, last, sel_q);
   end

   // Requests only steer the mux while idle; in BUSY the captured side is held.
   assign sel       = (state == IDLE) ? sel_idle : sel_q;
   assign capture   = (state == IDLE) && (req_a || req_b);
   assign handshake = (state != IDLE) && out_ready;

   // Data steering: the team mux is fixed at 4 bits, other widths use an
   // equivalent inline selector.
   generate
      if (W == 4) begin : g_team_mux
         mux u_mux (
            .A (data_a),
            .B (data_b),
            .s (sel),
            .Y (mux_y)
         );
      end else begin : g_wide_mux
         assign mux_y = (sel == SEL_B) ? data_b : data_a;
      end
   endgenerate

   // Control path: state, round-robin history, grants, valid and counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last       <= SEL_B;
         sel_q      <= SEL_A;
         gnt_a      <= 1'b0;
         gnt_b      <= 1'b0;
         y_valid    <= 1'b0;
         xfer_count <= '0;
      end else begin
         // Grants are single-cycle pulses that mark the capture edge only.
         gnt_a <= capture && (sel_idle == SEL_A);
         gnt_b <= capture && (sel_idle == SEL_B);
         case (state)
            IDLE: begin
               sel_q <= sel_idle;
               if (capture) begin
                  last    <= sel_idle;
                  y_valid <= 1'b1;
                  state   <= (sel_idle == SEL_B) ? BUSY_B : BUSY_A;
               end
            end
            BUSY_A, BUSY_B: begin
               if (handshake) begin
                  y_valid    <= 1'b0;
                  xfer_count <= xfer_count + CNT_W'(1);
                  state      <= IDLE;
               end
            end
            default: begin
               y_valid <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   // Output word register: loaded only on capture, otherwise holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y <= '0;
      end else if (capture) begin
         y <= mux_y;
      end
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with a scoreboard of expected words.
module tb_mux_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_a, req_b, out_ready;
   logic [3:0] data_a, data_b;
   logic       gnt_a, gnt_b, sel, y_valid;
   logic [3:0] y;
   logic [1:0] xfer_count;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [3:0] exp_q[$];
   logic [1:0] exp_cnt;
   logic       exp_last;
   logic       win_b;

   mux_rr_arbiter #(.W(4), .CNT_W(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_a      (req_a),
      .data_a     (data_a),
      .req_b      (req_b),
      .data_b     (data_b),
      .out_ready  (out_ready),
      .gnt_a      (gnt_a),
      .gnt_b      (gnt_b),
      .sel        (sel),
      .y          (y),
      .y_valid    (y_valid),
      .xfer_count (xfer_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Capture cycle: grant to the winner, word at the head of the scoreboard.
   task automatic check_capture(input string tag, input logic wb);
      logic [3:0] head;
      head = (exp_q.size() > 0) ? exp_q[0] : 4'hx;
      check({tag, ".gnt_a"}, gnt_a, !wb);
      check({tag, ".gnt_b"}, gnt_b, wb);
      check({tag, ".sel"}, sel, wb);
      check({tag, ".y_valid"}, y_valid, 1'b1);
      check({tag, ".y"}, y, head);
      exp_last = wb;
   endtask

   // Handshake completed: pop the word, valid drops, counter advances.
   task automatic check_done(input string tag);
      logic [3:0] head;
      head = 4'hx;
      if (exp_q.size() > 0) head = exp_q.pop_front();
      exp_cnt = exp_cnt + 2'd1;
      check({tag, ".y_valid"}, y_valid, 1'b0);
      check({tag, ".count"}, xfer_count, exp_cnt);
      check({tag, ".y_hold"}, y, head);
      check({tag, ".gnt"}, {gnt_a, gnt_b}, 2'b00);
   endtask

   initial begin
      rst = 1'b0; req_a = 1'b0; req_b = 1'b0; out_ready = 1'b0;
      data_a = 4'h0; data_b = 4'h0;
      exp_cnt = 2'd0; exp_last = 1'b1;

      // Asynchronous reset before any clock edge
      #2 rst = 1'b1;
      #1;
      check("rst.y", y, 4'h0);
      check("rst.y_valid", y_valid, 1'b0);
      check("rst.gnt", {gnt_a, gnt_b}, 2'b00);
      check("rst.sel", sel, 1'b0);
      check("rst.count", xfer_count, 2'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("idle.y_valid", y_valid, 1'b0);
      end

      // Single A request with immediate acceptance
      data_a = 4'b0110; req_a = 1'b1; out_ready = 1'b1;
      exp_q.push_back(4'b0110);
      step();
      check_capture("singleA", 1'b0);
      req_a = 1'b0;
      step();
      check_done("singleA");

      // Backpressure on a B word, B data changes while held
      data_b = 4'b0101; req_b = 1'b1; out_ready = 1'b0;
      exp_q.push_back(4'b0101);
      step();
      check_capture("bpB", 1'b1);
      req_b = 1'b0; data_b = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         step();
         check("bpB.y", y, 4'b0101);
         check("bpB.y_valid", y_valid, 1'b1);
         check("bpB.gnt_b", gnt_b, 1'b0);
         check("bpB.sel", sel, 1'b1);
      end
      out_ready = 1'b1;
      step();
      check_done("bpB");

      // Tie held: strict alternation starting with the side not served last
      data_a = 4'b0110; data_b = 4'b0101; req_a = 1'b1; req_b = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         win_b = !exp_last;
         exp_q.push_back(win_b ? data_b : data_a);
         step();
         check_capture("tie", win_b);
         check("tie.no_overlap", gnt_a & gnt_b, 1'b0);
         if (i == 3) begin
            req_a = 1'b0; req_b = 1'b0;
         end
         step();
         check_done("tie");
      end

      // Reset while a word is held in BUSY_A
      data_a = 4'b1001; req_a = 1'b1; out_ready = 1'b0;
      exp_q.push_back(4'b1001);
      step();
      check_capture("midrst", 1'b0);
      req_a = 1'b0;
      step();
      check("midrst.held", y_valid, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("midrst.y_valid", y_valid, 1'b0);
      check("midrst.count", xfer_count, 2'd0);
      check("midrst.y", y, 4'h0);
      exp_q.delete();
      exp_cnt = 2'd0; exp_last = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      data_a = 4'b0011; data_b = 4'b1100; req_a = 1'b1; req_b = 1'b1; out_ready = 1'b1;
      exp_q.push_back(4'b0011);
      step();
      check_capture("postrst", 1'b0);
      req_a = 1'b0; req_b = 1'b0;
      step();
      check_done("postrst");

      // Counter wrap with a 2-bit counter: 1 already, then 2,3,0,1
      for (int i = 0; i < 4; i++) begin
         data_a = 4'(i + 7); req_a = 1'b1;
         exp_q.push_back(4'(i + 7));
         step();
         check_capture("wrap", 1'b0);
         req_a = 1'b0;
         step();
         check_done("wrap");
      end

      // out_ready in IDLE has no effect
      out_ready = 1'b1;
      step();
      check("idle_ready.count", xfer_count, exp_cnt);
      check("idle_ready.y_valid", y_valid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
